// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gfx_pkg
//  Brief    : Shared graphics types: coordinate vector, cull FSM states and
//             a shift-then-saturate helper for fixed-point narrowing.
//  Revision : 1.0 - initial release
// ============================================================================
package gfx_pkg;

  localparam int COORD_W = 16;

  // Packed 3-vector of signed coordinates, index 0 = x
  typedef logic signed [2:0][COORD_W-1:0] vec3_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CX     = 3'd1,
    CY     = 3'd2,
    CZ     = 3'd3,
    DOT    = 3'd4,
    DECIDE = 3'd5,
    OUT    = 3'd6
  } cull_state_t;

  // Arithmetic (floor) right shift, then clamp into a signed out_w-bit range.
  // Callers size-cast the result down to out_w bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] val,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = val >>> shift;
    max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v) begin
      return max_v;
    end else if (shifted < min_v) begin
      return min_v;
    end
    return shifted;
  endfunction

endpackage : gfx_pkg
`default_nettype wire

// File: rtl/fixed_point_fast_dot.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_fast_dot
//  Brief    : Combinational signed 3-element fixed-point dot product with
//             floor rescaling to the output format and saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_point_fast_dot
  import gfx_pkg::*;
#(
  parameter int A_WIDTH     = 16,
  parameter int A_FRAC_BITS = 14,
  parameter int B_WIDTH     = 16,
  parameter int B_FRAC_BITS = 14,
  parameter int P_WIDTH     = 16,
  parameter int P_FRAC_BITS = 14
) (
  input  logic signed [2:0][A_WIDTH-1:0] a_in,
  input  logic signed [2:0][B_WIDTH-1:0] b_in,
  output logic signed [P_WIDTH-1:0]      p_out
);

  // Two guard bits cover the sum of three full-width products
  localparam int SUM_W = A_WIDTH + B_WIDTH + 2;
  localparam int SHIFT = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS;

  logic signed [SUM_W-1:0] w_sum;

  // Sign-extend operands to the accumulator width before multiplying
  always_comb begin : p_sum
    logic signed [SUM_W-1:0] a_ext;
    logic signed [SUM_W-1:0] b_ext;
    w_sum = '0;
    a_ext = '0;
    b_ext = '0;
    for (int i = 0; i < 3; i++) begin
      a_ext = SUM_W'($signed(a_in[i]));
      b_ext = SUM_W'($signed(b_in[i]));
      w_sum = w_sum + a_ext * b_ext;
    end
  end

  assign p_out = P_WIDTH'(sat_shift(64'(w_sum), SHIFT, P_WIDTH));

endmodule : fixed_point_fast_dot
`default_nettype wire

// File: rtl/backface_cull.sv
`default_nettype none
// ============================================================================
//  Module   : backface_cull
//  Brief    : Sequential back-face culling stage. Computes the face normal
//             one component per cycle on a shared multiplier pair, dots it
//             with the view direction, forwards front-facing triangles and
//             counts the dropped ones.
//  Revision : 1.0 - initial release
// ============================================================================
module backface_cull
  import gfx_pkg::*;
#(
  parameter int C_WIDTH     = 16,
  parameter int C_FRAC_BITS = 14,
  parameter int N_WIDTH     = 16,
  parameter int N_FRAC_BITS = 14,
  parameter int P_WIDTH     = 16,
  parameter int P_FRAC_BITS = 14,
  parameter int ID_WIDTH    = 12
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          s_valid_in,
  output logic                          s_ready_out,
  input  logic [ID_WIDTH-1:0]           tri_id_in,
  input  logic signed [2:0][C_WIDTH-1:0] v0_in,
  input  logic signed [2:0][C_WIDTH-1:0] v1_in,
  input  logic signed [2:0][C_WIDTH-1:0] v2_in,
  input  logic signed [2:0][C_WIDTH-1:0] view_in,
  output logic                          m_valid_out,
  input  logic                          m_ready_in,
  output logic [ID_WIDTH-1:0]           tri_id_out,
  output logic signed [2:0][C_WIDTH-1:0] v0_out,
  output logic signed [2:0][C_WIDTH-1:0] v1_out,
  output logic signed [2:0][C_WIDTH-1:0] v2_out,
  output logic signed [P_WIDTH-1:0]     facing_out,
  output logic [15:0]                   cull_count_out,
  input  logic                          count_clr_in
);

  localparam int E_WIDTH = C_WIDTH + 1;        // edge width, no overflow on v1-v0
  localparam int D_WIDTH = 2 * E_WIDTH + 1;    // difference of two edge products
  localparam int X_SHIFT = 2 * C_FRAC_BITS - N_FRAC_BITS;

  cull_state_t r_state;
  cull_state_t w_next;
  logic        r_rdy;
  logic        w_accept;
  logic        w_cull;

  logic signed [2:0][C_WIDTH-1:0] r_view;
  logic signed [2:0][N_WIDTH-1:0] r_nrm;

  logic signed [E_WIDTH-1:0] w_e1 [3];
  logic signed [E_WIDTH-1:0] w_e2 [3];
  logic signed [E_WIDTH-1:0] w_a1, w_b1, w_a2, w_b2;
  logic signed [D_WIDTH-1:0] w_p1, w_p2, w_diff;
  logic signed [N_WIDTH-1:0] w_ncomp;
  logic signed [P_WIDTH-1:0] w_dot;

  assign w_accept    = s_valid_in && r_rdy;
  assign w_cull      = (r_state == DECIDE) && !facing_out[P_WIDTH-1];
  assign s_ready_out = r_rdy;
  assign m_valid_out = (r_state == OUT);

  // Edges are formed from the latched vertices (held in the output registers)
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_e1[i] = E_WIDTH'($signed(v1_out[i])) - E_WIDTH'($signed(v0_out[i]));
      w_e2[i] = E_WIDTH'($signed(v2_out[i])) - E_WIDTH'($signed(v0_out[i]));
    end
  end

  // Route edge components onto the shared multiplier pair for the current axis
  always_comb begin
    w_a1 = w_e1[1];
    w_b1 = w_e2[2];
    w_a2 = w_e1[2];
    w_b2 = w_e2[1];
    case (r_state)
      CY: begin
        w_a1 = w_e1[2];
        w_b1 = w_e2[0];
        w_a2 = w_e1[0];
        w_b2 = w_e2[2];
      end
      CZ: begin
        w_a1 = w_e1[0];
        w_b1 = w_e2[1];
        w_a2 = w_e1[1];
        w_b2 = w_e2[0];
      end
      default: ;
    endcase
  end

  assign w_p1    = w_a1 * w_b1;
  assign w_p2    = w_a2 * w_b2;
  assign w_diff  = w_p1 - w_p2;
  assign w_ncomp = N_WIDTH'(sat_shift(64'(w_diff), X_SHIFT, N_WIDTH));

  fixed_point_fast_dot #(
    .A_WIDTH     (N_WIDTH),
    .A_FRAC_BITS (N_FRAC_BITS),
    .B_WIDTH     (C_WIDTH),
    .B_FRAC_BITS (C_FRAC_BITS),
    .P_WIDTH     (P_WIDTH),
    .P_FRAC_BITS (P_FRAC_BITS)
  ) u_dot (
    .a_in  (r_nrm),
    .b_in  (r_view),
    .p_out (w_dot)
  );

  // Next-state decode; a negative dot means the triangle faces the camera
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CX;
      CX:      w_next = CY;
      CY:      w_next = CZ;
      CZ:      w_next = DOT;
      DOT:     w_next = DECIDE;
      DECIDE:  w_next = facing_out[P_WIDTH-1] ? OUT : IDLE;
      OUT:     if (m_ready_in) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; ready is registered so it stays low while reset is held
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next == IDLE);
    end
  end

  // Capture the triangle at accept, then fill normal and dot one step at a time
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tri_id_out <= '0;
      v0_out     <= '0;
      v1_out     <= '0;
      v2_out     <= '0;
      r_view     <= '0;
      r_nrm      <= '0;
      facing_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            tri_id_out <= tri_id_in;
            v0_out     <= v0_in;
            v1_out     <= v1_in;
            v2_out     <= v2_in;
            r_view     <= view_in;
          end
        end
        CX:      r_nrm[0]   <= w_ncomp;
        CY:      r_nrm[1]   <= w_ncomp;
        CZ:      r_nrm[2]   <= w_ncomp;
        DOT:     facing_out <= w_dot;
        default: ;
      endcase
    end
  end

  // Culled-triangle counter; clear takes priority over a same-cycle increment
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cull_count_out <= '0;
    end else if (count_clr_in) begin
      cull_count_out <= '0;
    end else if (w_cull) begin
      cull_count_out <= cull_count_out + 16'd1;
    end
  end

endmodule : backface_cull
`default_nettype wire

// File: tb/tb_backface_cull.sv
`default_nettype none
// ============================================================================
//  Module   : tb_backface_cull
//  Brief    : Directed self-checking bench for backface_cull.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_backface_cull;
  import gfx_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        s_valid_in;
  logic        s_ready_out;
  logic [11:0] tri_id_in;
  vec3_t       v0_in, v1_in, v2_in, view_in;
  logic        m_valid_out;
  logic        m_ready_in;
  logic [11:0] tri_id_out;
  vec3_t       v0_out, v1_out, v2_out;
  logic signed [15:0] facing_out;
  logic [15:0] cull_count_out;
  logic        count_clr_in;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  backface_cull dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .s_valid_in     (s_valid_in),
    .s_ready_out    (s_ready_out),
    .tri_id_in      (tri_id_in),
    .v0_in          (v0_in),
    .v1_in          (v1_in),
    .v2_in          (v2_in),
    .view_in        (view_in),
    .m_valid_out    (m_valid_out),
    .m_ready_in     (m_ready_in),
    .tri_id_out     (tri_id_out),
    .v0_out         (v0_out),
    .v1_out         (v1_out),
    .v2_out         (v2_out),
    .facing_out     (facing_out),
    .cull_count_out (cull_count_out),
    .count_clr_in   (count_clr_in)
  );

  function automatic vec3_t mk(input int x, input int y, input int z);
    vec3_t v;
    v[0] = 16'(x);
    v[1] = 16'(y);
    v[2] = 16'(z);
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int id, input vec3_t a, input vec3_t b,
                      input vec3_t c, input vec3_t vw);
    s_valid_in = 1'b1;
    tri_id_in  = 12'(id);
    v0_in      = a;
    v1_in      = b;
    v2_in      = c;
    view_in    = vw;
    tick();
    s_valid_in = 1'b0;
  endtask

  // From just after the accept edge, step to just after the DECIDE edge
  task automatic to_decide(input string tag, input logic pass);
    repeat (4) tick();
    check({tag, "_busy_mvalid"}, 64'(m_valid_out), 64'd0);
    check({tag, "_busy_sready"}, 64'(s_ready_out), 64'd0);
    tick();
    check({tag, "_mvalid"}, 64'(m_valid_out), 64'(pass));
  endtask

  vec3_t z0, xh, yh, vneg, s0, s1, s2;

  initial begin
    z0   = mk(0, 0, 0);
    xh   = mk(8192, 0, 0);
    yh   = mk(0, 8192, 0);
    vneg = mk(0, 0, -16384);
    s0   = mk(-31130, -31130, 0);
    s1   = mk(31130, -31130, 0);
    s2   = mk(-31130, 31130, 0);

    rst_in       = 1'b1;
    s_valid_in   = 1'b0;
    tri_id_in    = '0;
    v0_in        = '0;
    v1_in        = '0;
    v2_in        = '0;
    view_in      = '0;
    m_ready_in   = 1'b1;
    count_clr_in = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_sready", 64'(s_ready_out), 64'd0);
    check("rst_mvalid", 64'(m_valid_out), 64'd0);
    check("rst_count", 64'(cull_count_out), 64'd0);
    check("rst_facing", 64'(facing_out), 64'd0);
    check("rst_id", 64'(tri_id_out), 64'd0);
    check("rst_v0", 64'(v0_out), 64'd0);
    rst_in = 1'b0;
    tick();
    check("rel_sready", 64'(s_ready_out), 64'd1);

    // Front-facing pass
    send(5, z0, xh, yh, vneg);
    to_decide("front", 1'b1);
    check("front_facing", 64'(facing_out), -64'sd4096);
    check("front_id", 64'(tri_id_out), 64'd5);
    check("front_v0", 64'(v0_out), 64'(z0));
    check("front_v1", 64'(v1_out), 64'(xh));
    check("front_v2", 64'(v2_out), 64'(yh));
    check("front_count", 64'(cull_count_out), 64'd0);
    tick();
    check("front_done_mvalid", 64'(m_valid_out), 64'd0);
    check("front_done_sready", 64'(s_ready_out), 64'd1);

    // Back-facing cull
    send(6, z0, yh, xh, vneg);
    to_decide("back", 1'b0);
    check("back_count", 64'(cull_count_out), 64'd1);
    check("back_sready", 64'(s_ready_out), 64'd1);

    // Degenerate triangle
    send(7, z0, xh, xh, vneg);
    to_decide("degen", 1'b0);
    check("degen_count", 64'(cull_count_out), 64'd2);

    // Saturated normal
    send(8, s0, s1, s2, vneg);
    to_decide("sat", 1'b1);
    check("sat_facing", 64'(facing_out), -64'sd32767);
    tick();

    // Backpressure: hold OUT for 10 cycles
    m_ready_in = 1'b0;
    send(9, z0, xh, yh, vneg);
    to_decide("bp", 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_mvalid", 64'(m_valid_out), 64'd1);
      check("bp_sready", 64'(s_ready_out), 64'd0);
      check("bp_facing", 64'(facing_out), -64'sd4096);
      check("bp_id", 64'(tri_id_out), 64'd9);
    end
    m_ready_in = 1'b1;
    s_valid_in = 1'b1;
    tri_id_in  = 12'd10;
    tick();
    check("bp_hs_mvalid", 64'(m_valid_out), 64'd0);
    check("bp_hs_sready", 64'(s_ready_out), 64'd1);
    tick();
    s_valid_in = 1'b0;
    check("bp_next_accept", 64'(s_ready_out), 64'd0);
    to_decide("bp_next", 1'b1);
    check("bp_next_id", 64'(tri_id_out), 64'd10);
    tick();

    // Reset mid-operation during CY
    send(11, z0, yh, xh, vneg);
    tick();
    rst_in = 1'b1;
    #1;
    check("midrst_sready", 64'(s_ready_out), 64'd0);
    check("midrst_mvalid", 64'(m_valid_out), 64'd0);
    check("midrst_facing", 64'(facing_out), 64'd0);
    tick();
    rst_in = 1'b0;
    tick();
    check("midrst_rel_sready", 64'(s_ready_out), 64'd1);
    repeat (6) tick();
    check("midrst_count", 64'(cull_count_out), 64'd0);
    check("midrst_mvalid_after", 64'(m_valid_out), 64'd0);

    // Build count to 3, then clear on the same edge as a cull
    for (int i = 0; i < 3; i++) begin
      send(20 + i, z0, yh, xh, vneg);
      to_decide("fill", 1'b0);
    end
    check("fill_count", 64'(cull_count_out), 64'd3);
    send(30, z0, yh, xh, vneg);
    repeat (4) tick();
    count_clr_in = 1'b1;
    tick();
    count_clr_in = 1'b0;
    check("clr_collide_count", 64'(cull_count_out), 64'd0);
    check("clr_collide_sready", 64'(s_ready_out), 64'd1);

    // Clear while idle
    send(31, z0, yh, xh, vneg);
    to_decide("idleclr", 1'b0);
    check("idleclr_pre", 64'(cull_count_out), 64'd1);
    count_clr_in = 1'b1;
    tick();
    count_clr_in = 1'b0;
    check("idleclr_post", 64'(cull_count_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_backface_cull
`default_nettype wire

// File: doc/backface_cull.md
# backface_cull

Sequential triangle back-face culling stage feeding the rasterizer. Accepts one screen-ready triangle (three signed fixed-point vertices) over a valid/ready handshake, computes the face normal with a cross product one component per cycle, then dots it with the camera view direction using `fixed_point_fast_dot`. Front-facing triangles go downstream with their dot value; back-facing and degenerate triangles are dropped and counted.

## Interface
Parameters:
- `C_WIDTH`, 16, vertex/view coordinate width (signed)
- `C_FRAC_BITS`, 14, fractional bits of coordinates
- `N_WIDTH`, 16, normal component width
- `N_FRAC_BITS`, 14, fractional bits of normal
- `P_WIDTH`, 16, dot-product output width
- `P_FRAC_BITS`, 14, fractional bits of dot output
- `ID_WIDTH`, 12, triangle id width

Ports:
- One clock; reset is asynchronous and active-high.
- `clk_in` in 1: system clock
- `rst_in` in 1: async active-high reset
- `s_valid_in` in 1: input triangle valid
- `s_ready_out` out 1: stage can accept
- `tri_id_in` in ID_WIDTH: triangle id
- `v0_in`, `v1_in`, `v2_in` in [2:0][C_WIDTH-1:0] signed: vertices, index 0 = x
- `view_in` in [2:0][C_WIDTH-1:0] signed: view direction, sampled at accept
- `m_valid_out` out 1: output triangle valid
- `m_ready_in` in 1: downstream accepts
- `tri_id_out` out ID_WIDTH; `v0_out`, `v1_out`, `v2_out` out [2:0][C_WIDTH-1:0]: passed-through triangle
- `facing_out` out P_WIDTH signed: normal·view
- `cull_count_out` out 16: culled-triangle counter
- `count_clr_in` in 1: synchronous counter clear

## Operation
- FSM states: IDLE, CX, CY, CZ, DOT, DECIDE, OUT.
- IDLE: `s_ready_out`=1. On `s_valid_in`, latch id, vertices and view. Form edges e1=v1−v0, e2=v2−v0, sign-extended to C_WIDTH+1 bits. Go to CX.
- CX/CY/CZ: one normal component per state.
  - n.x = e1.y·e2.z − e1.z·e2.y; n.y = e1.z·e2.x − e1.x·e2.z; n.z = e1.x·e2.y − e1.y·e2.x.
  - Products are full width, 2·C_FRAC_BITS fractional bits.
  - Arithmetic shift right by 2·C_FRAC_BITS−N_FRAC_BITS (floor), then saturate to N_WIDTH.
- DOT: register the `fixed_point_fast_dot(normal, view)` result (A=N, B=C, P=P params).
- DECIDE:
  - dot < 0: front-facing, go to OUT.
  - dot ≥ 0, including a zero normal: culled. Increment `cull_count_out` (wraps at 2^16) and return to IDLE.
- OUT: `m_valid_out`=1 with stable outputs until `m_ready_in`, then IDLE.
- `s_ready_out`=0 in every state except IDLE. Only one triangle is in flight.
- `count_clr_in` zeroes the counter the next edge. Clear wins over a simultaneous increment (result 0).
- Reset values:
  - state IDLE; `s_ready_out` 0 while `rst_in` high, 1 on the first cycle after release
  - `m_valid_out` 0; all data outputs 0; `cull_count_out` 0
- Reset mid-operation: the in-flight triangle is discarded and not counted.

## Timing
- Accept edge = cycle 0. CX at 1, CY 2, CZ 3, DOT 4, DECIDE 5.
- `m_valid_out` rises at cycle 6 when `m_ready_in` is high.
- IDLE is re-entered the cycle after the handshake or after DECIDE (cull).
- Minimum spacing: 7 cycles per passing triangle, 6 per culled triangle.
- Outputs are registered. `s_ready_out` and `m_valid_out` are decoded from registered state.

## Structure
- Shared package `gfx_pkg` holds:
  - `vec3_t`, a packed [2:0] signed coordinate typedef
  - `cull_state_t` enum
  - `sat_shift` function: shift then saturate, parameterised by widths
- One sub-module instance: existing `fixed_point_fast_dot`.
- Edge and cross logic is inline, with one time-shared multiplier pair.

## Test plan
All values Q2.14 (1.0 = 16384).
- **Front-facing pass:** v0=(0,0,0), v1=(8192,0,0), v2=(0,8192,0), view=(0,0,−16384), id 5 -> `m_valid_out` at cycle 6, `facing_out`=−4096, id 5, vertices unchanged, count 0.
- **Back-facing cull:** swap v1/v2 of the previous case -> no `m_valid_out`, `cull_count_out`=1, `s_ready_out`=1 at cycle 6. Degenerate v1=v2 -> also culled, count 2.
- **Saturation:** v0=(−31130,−31130,0), v1=(31130,−31130,0), v2=(−31130,31130,0), view=(0,0,−16384) -> n.z saturates to 32767, `facing_out`=−32767, passes.
- **Backpressure:** `m_ready_in` low for 10 cycles in OUT -> outputs stable, `s_ready_out`=0. Next triangle is accepted the cycle after IDLE is re-entered.
- **Reset mid-operation:** `rst_in` pulsed during CY -> `m_valid_out` 0, counter unchanged, `s_ready_out`=1 after release.
- **Clear collision:** `count_clr_in` asserted in the same cycle as a DECIDE cull with count 3 -> count 0.
